// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with phase-delayed start and
// glitch-free reconfiguration applied only at a channel's period boundary.
module clk_div_gen #(
  parameter int NUM_CLOCKS  = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RST = (DEFAULT_DIV < 2) ? DIV_MIN : DIV_W'(DEFAULT_DIV);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  typedef enum logic [1:0] {SETTLE, IDLE, WAIT_BND} state_t;

  state_t            state_reg, state_next;
  logic [SET_W-1:0]  settle_cnt_reg, settle_cnt_next;
  logic [CH_W-1:0]   tgt_reg, tgt_next;
  logic [DIV_W-1:0]  div_new_reg, div_new_next;
  logic [DIV_W-1:0]  phase_new_reg, phase_new_next;
  logic              chan_ok;
  logic [NUM_CLOCKS-1:0] load_ch;

  // When the channel field can only encode existing channels every index is legal.
  if (NUM_CLOCKS == (1 << CH_W)) begin : g_chan_full
    assign chan_ok = 1'b1;
  end else begin : g_chan_part
    localparam logic [CH_W-1:0] NUM_CH = CH_W'(NUM_CLOCKS);
    assign chan_ok = (cfg_chan < NUM_CH);
  end

  assign cfg_ready = (state_reg == IDLE);
  assign locked    = (state_reg == IDLE);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= SETTLE;
      settle_cnt_reg <= '0;
      tgt_reg        <= '0;
      div_new_reg    <= '0;
      phase_new_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      tgt_reg        <= tgt_next;
      div_new_reg    <= div_new_next;
      phase_new_reg  <= phase_new_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    tgt_next        = tgt_reg;
    div_new_next    = div_new_reg;
    phase_new_next  = phase_new_reg;
    case (state_reg)
      SETTLE: begin
        if (settle_cnt_reg == SET_W'(LOCK_CYCLES - 1)) begin
          state_next      = IDLE;
          settle_cnt_next = '0;
        end else begin
          settle_cnt_next = settle_cnt_reg + SET_W'(1);
        end
      end
      IDLE: begin
        // Requests to nonexistent channels are dropped without leaving IDLE.
        if (cfg_valid && chan_ok) begin
          tgt_next       = cfg_chan;
          div_new_next   = cfg_div;
          phase_new_next = cfg_phase;
          state_next     = WAIT_BND;
        end
      end
      WAIT_BND: begin
        if (|load_ch) begin
          state_next      = SETTLE;
          settle_cnt_next = '0;
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_ch
    logic [DIV_W-1:0] div_eff_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] pd_reg;
    logic             out_reg;
    logic             at_bnd;

    assign at_bnd      = (pd_reg == '0) && (cnt_reg == div_eff_reg - DIV_W'(1));
    assign load_ch[gi] = (state_reg == WAIT_BND) && (tgt_reg == CH_W'(gi)) && at_bnd;
    assign outclk[gi]  = out_reg;

    // Loading only on the last low cycle keeps every high and low phase whole.
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        div_eff_reg <= DIV_RST;
        cnt_reg     <= '0;
        pd_reg      <= '0;
        out_reg     <= 1'b0;
      end else if (load_ch[gi]) begin
        div_eff_reg <= clamp_div(div_new_reg);
        cnt_reg     <= '0;
        pd_reg      <= phase_new_reg;
        out_reg     <= 1'b0;
      end else if (pd_reg != '0) begin
        pd_reg  <= pd_reg - DIV_W'(1);
        cnt_reg <= '0;
        out_reg <= 1'b0;
      end else begin
        out_reg <= (cnt_reg < (div_eff_reg >> 1));
        cnt_reg <= at_bnd ? '0 : cnt_reg + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: stimulus queues hand-derived per-cycle
// waveforms, a negedge monitor pops and compares them against the outputs.
module tb_clk_div_gen;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       cfg_valid, cfg_ready, locked;
  logic [0:0] cfg_chan;
  logic [7:0] cfg_div, cfg_phase;
  logic [1:0] outclk;

  // Second instance with three channels so an out-of-range index is expressible.
  logic       cfg_valid3, cfg_ready3, locked3;
  logic [1:0] cfg_chan3;
  logic [2:0] outclk3;

  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_tag  = "";

  typedef struct packed {
    byte o0;
    byte o1;
    byte lk;
    byte o3;
    byte l3;
    int  idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  clk_div_gen u_dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .locked    (locked)
  );

  clk_div_gen #(.NUM_CLOCKS(3)) u_dut3 (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_chan  (cfg_chan3),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .outclk    (outclk3),
    .locked    (locked3)
  );

  always #5 refclk = ~refclk;

  function automatic byte pick(input string s, input int i);
    if (i < s.len()) return s[i];
    return 8'h2d;
  endfunction

  function automatic string rep(input string s, input int n);
    string r;
    r = "";
    for (int i = 0; i < n; i++) r = {r, s};
    return r;
  endfunction

  task automatic chk(input string what, input int idx, input byte c, input logic act);
    if (c != 8'h2d) begin
      n_checks++;
      if (act !== (c == 8'h31)) begin
        n_fail++;
        $display("FAIL %s[%0d] %s got=%b want=%b", cur_tag, idx, what, act, (c == 8'h31));
      end
    end
  endtask

  always @(negedge refclk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("outclk[0]", mon_e.idx, mon_e.o0, outclk[0]);
      chk("outclk[1]", mon_e.idx, mon_e.o1, outclk[1]);
      chk("locked", mon_e.idx, mon_e.lk, locked);
      chk("cfg_ready", mon_e.idx, mon_e.lk, cfg_ready);
      for (int j = 0; j < 3; j++)
        chk($sformatf("dut3.outclk[%0d]", j), mon_e.idx, mon_e.o3, outclk3[j]);
      chk("dut3.locked", mon_e.idx, mon_e.l3, locked3);
      chk("dut3.cfg_ready", mon_e.idx, mon_e.l3, cfg_ready3);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Entry 0 of a segment is the state after the edge just before the push.
  task automatic expect_seg(input string tag, input string w0, input string w1,
                            input string wl, input string w3, input string wl3);
    exp_t e;
    cur_tag = tag;
    for (int i = 0; i < wl.len(); i++) begin
      e.o0  = pick(w0, i);
      e.o1  = pick(w1, i);
      e.lk  = pick(wl, i);
      e.o3  = pick(w3, i);
      e.l3  = pick(wl3, i);
      e.idx = i;
      exp_q.push_back(e);
    end
  endtask

  task automatic sync_empty();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge refclk);
      #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s drain pending=%0d want=0", cur_tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send(input int ch, input int dv, input int ph);
    cfg_chan  = 1'(ch);
    cfg_div   = 8'(dv);
    cfg_phase = 8'(ph);
    cfg_valid = 1'b1;
    $display("cfg chan=%0d div=%0d phase=%0d", ch, dv, ph);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string a_clk, a_lk;
    a_clk = {"0", rep("1100", 5)};
    a_lk  = {rep("0", 16), rep("1", 5)};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0; cfg_phase = '0;
    cfg_valid3 = 1'b0; cfg_chan3 = '0;
    step(1);
    expect_seg("reset", "00", "00", "00", "00", "00");
    sync_empty();

    // Release: refclk/4 on every channel, lock after 16 edges.
    rst_n = 1'b1;
    expect_seg("release", a_clk, a_clk, a_lk, a_clk, a_lk);
    sync_empty();

    // Retune ch1 to div 6 / phase 3 while it is high.
    expect_seg("retune_ch1", {rep("1100", 5), "11"}, "1100000111000111000111",
               {"1", rep("0", 18), "111"}, {rep("1100", 5), "11"}, rep("1", 22));
    send(1, 6, 3);
    step(1);
    cfg_valid = 1'b0;
    sync_empty();

    expect_seg("div0", rep("0011", 5), {"000", rep("10", 8), "1"},
               {"1", rep("0", 17), "11"}, "", "");
    send(1, 0, 0);
    step(1);
    cfg_valid = 1'b0;
    sync_empty();

    expect_seg("div1", rep("0011", 5), rep("01", 10), {"1", rep("0", 17), "11"}, "", "");
    send(1, 1, 0);
    step(1);
    cfg_valid = 1'b0;
    sync_empty();

    expect_seg("div5", "0011001100011000110001", rep("01", 11),
               {"1", rep("0", 20), "1"}, "", "");
    send(0, 5, 0);
    step(1);
    cfg_valid = 1'b0;
    sync_empty();

    // Out-of-range channel on the three-channel instance is discarded.
    expect_seg("bad_chan", "10001100", "01010101", "11111111", "11001100", "11111111");
    cfg_chan3  = 2'd3;
    cfg_valid3 = 1'b1;
    $display("cfg dut3 chan=3 div=%0d phase=%0d", cfg_div, cfg_phase);
    step(2);
    cfg_valid3 = 1'b0;
    sync_empty();

    // Second request held through WAIT_BND and SETTLE; accepted on first IDLE cycle.
    expect_seg("hold_valid", {"0", rep("11000", 3), "11", "00000", rep("100", 5)},
               {"010", rep("1100", 8), "110"},
               {"1", rep("0", 17), "1", rep("0", 17), "11"}, "", "");
    send(1, 4, 0);
    step(1);
    send(0, 3, 2);
    step(18);
    cfg_valid = 1'b0;
    sync_empty();

    // Reset asserted while a request waits for its boundary.
    expect_seg("rst_wait", "10000", "01000", "10000", "00000", "11000");
    send(1, 8, 5);
    step(1);
    cfg_valid = 1'b0;
    step(1);
    rst_n = 1'b0;
    sync_empty();

    rst_n = 1'b1;
    expect_seg("rerelease", a_clk, a_clk, a_lk, a_clk, a_lk);
    sync_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
